// File: rtl/scan_alu_pkg.sv
// Shared opcode encodings and chain geometry for the scan ALU slice.
package scan_alu_pkg;

  localparam int unsigned OPCODE_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // A + B + opcode + result + zero
  function automatic int unsigned chain_len(input int unsigned width);
    return 3 * width + OPCODE_W + 1;
  endfunction

endpackage

// File: rtl/alu_core_p.sv
// Purely combinational WIDTH-bit ALU; results truncated to WIDTH bits.
module alu_core_p
  import scan_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  y = a << 1;
      OP_SHR:  y = a >> 1;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/scan_alu_dft.sv
// Scan-wrapped ALU slice: full chain over operands, opcode and result/zero capture cells.
// Optional MISR signature output enabled by defining SCAN_ALU_MISR_EN.
module scan_alu_dft
  import scan_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in,
  input  logic             scan_enable,
  input  logic             capture_en,
  input  logic             test_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             scan_out,
`ifdef SCAN_ALU_MISR_EN
  output logic             shift_done,
  output logic [WIDTH:0]   misr_sig
`else
  output logic             shift_done
`endif
);

  localparam int unsigned CHAIN_LEN = chain_len(WIDTH);
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned OP_LSB    = WIDTH + 1;
  localparam int unsigned B_LSB     = WIDTH + OPCODE_W + 1;
  localparam int unsigned A_LSB     = 2 * WIDTH + OPCODE_W + 1;

  logic [CHAIN_LEN-1:0] chain_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             capture;

  // Operand source follows test_mode only; shifting does not freeze the ALU inputs.
  always_comb begin
    alu_a  = A;
    alu_b  = B;
    alu_op = opcode;
    if (test_mode) begin
      alu_a  = chain_q[A_LSB +: WIDTH];
      alu_b  = chain_q[B_LSB +: WIDTH];
      alu_op = chain_q[OP_LSB +: OPCODE_W];
    end
  end

  alu_core_p #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Shift has priority over capture.
  assign capture = capture_en & ~scan_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else if (scan_enable) begin
      chain_q <= {chain_q[CHAIN_LEN-2:0], scan_in};
    end else if (capture) begin
      chain_q[WIDTH:0] <= {alu_y, alu_zero};
    end
  end

  assign scan_out = chain_q[CHAIN_LEN-1];

  // Counts consecutive shifts only; any idle cycle restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      shift_done <= 1'b0;
    end else if (scan_enable) begin
      if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
        cnt_q      <= '0;
        shift_done <= 1'b1;
      end else begin
        cnt_q      <= cnt_q + CNT_W'(1);
        shift_done <= 1'b0;
      end
    end else begin
      cnt_q      <= '0;
      shift_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      zero_flag <= 1'b1;
    end else begin
      result    <= alu_y;
      zero_flag <= alu_zero;
    end
  end

`ifdef SCAN_ALU_MISR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misr_sig <= '0;
    end else if (capture) begin
      misr_sig <= {misr_sig[WIDTH-1:0], misr_sig[WIDTH] ^ misr_sig[0]} ^ {alu_y, alu_zero};
    end
  end
`endif

endmodule

// File: tb/tb_scan_alu_dft.sv
// Directed self-checking bench for scan_alu_dft at WIDTH=4 (chain length 16).
module tb_scan_alu_dft;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_enable = 1'b0;
  logic       capture_en = 1'b0;
  logic       test_mode = 1'b0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic [2:0] opcode = 3'b000;
  logic [3:0] result;
  logic       zero_flag;
  logic       scan_out;
  logic       shift_done;
`ifdef SCAN_ALU_MISR_EN
  logic [4:0] misr_sig;
`endif

  int total = 0;
  int bad   = 0;

  scan_alu_dft #(
    .WIDTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in     (scan_in),
    .scan_enable (scan_enable),
    .capture_en  (capture_en),
    .test_mode   (test_mode),
    .A           (A),
    .B           (B),
    .opcode      (opcode),
    .result      (result),
    .zero_flag   (zero_flag),
    .scan_out    (scan_out),
`ifdef SCAN_ALU_MISR_EN
    .shift_done  (shift_done),
    .misr_sig    (misr_sig)
`else
    .shift_done  (shift_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs[12];

  logic [15:0] load_pat;
  logic [15:0] cap_pat;

  initial begin
    vecs[0]  = '{4'h5, 4'h5, 3'b001, 4'h0, 1'b1};
    vecs[1]  = '{4'hF, 4'h1, 3'b000, 4'h0, 1'b1};
    vecs[2]  = '{4'h3, 4'h5, 3'b000, 4'h8, 1'b0};
    vecs[3]  = '{4'h3, 4'h5, 3'b001, 4'hE, 1'b0};
    vecs[4]  = '{4'hC, 4'hA, 3'b010, 4'h8, 1'b0};
    vecs[5]  = '{4'hC, 4'hA, 3'b011, 4'hE, 1'b0};
    vecs[6]  = '{4'hC, 4'hA, 3'b100, 4'h6, 1'b0};
    vecs[7]  = '{4'h5, 4'h3, 3'b101, 4'hA, 1'b0};
    vecs[8]  = '{4'h9, 4'h0, 3'b110, 4'h2, 1'b0};
    vecs[9]  = '{4'h9, 4'h0, 3'b111, 4'h4, 1'b0};
    vecs[10] = '{4'hF, 4'h0, 3'b101, 4'h0, 1'b1};
    vecs[11] = '{4'h7, 4'h7, 3'b100, 4'h0, 1'b1};

    load_pat = 16'b0011_0101_000_0000_0;
    cap_pat  = 16'b0011_0101_000_1000_0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_result", 32'(result), 32'h0);
    check("reset_zero", 32'(zero_flag), 32'h1);
    check("reset_scan_out", 32'(scan_out), 32'h0);
    check("reset_shift_done", 32'(shift_done), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset asserted mid-shift, between clock edges
    test_mode   = 1'b0;
    A           = 4'h1;
    B           = 4'h1;
    opcode      = 3'b000;
    scan_in     = 1'b1;
    scan_enable = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("midshift_result_pre", 32'(result), 32'h2);
    #3 reset = 1'b1;
    #1;
    check("midshift_rst_result", 32'(result), 32'h0);
    check("midshift_rst_zero", 32'(zero_flag), 32'h1);
    check("midshift_rst_scan_out", 32'(scan_out), 32'h0);
    check("midshift_rst_shift_done", 32'(shift_done), 32'h0);
    tick();
    reset       = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;

    // Full chain load in test mode; counter must start from zero after reset
    test_mode = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      scan_in     = load_pat[i];
      scan_enable = 1'b1;
      tick();
      check($sformatf("load_shift_done[%0d]", 15 - i), 32'(shift_done), 32'(i == 0));
    end
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    tick();
    check("load_done_pulse_end", 32'(shift_done), 32'h0);
    check("load_result", 32'(result), 32'h8);
    check("load_zero", 32'(zero_flag), 32'h0);

    // Capture then unload the whole chain
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    check("capture_result_stable", 32'(result), 32'h8);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("unload_scan_out[%0d]", k), 32'(scan_out), 32'(cap_pat[15 - k]));
      scan_in     = 1'b0;
      scan_enable = 1'b1;
      tick();
      check($sformatf("unload_shift_done[%0d]", k), 32'(shift_done), 32'(k == 15));
    end

    // Shift beats capture; a gap restarts the shift count
    test_mode  = 1'b0;
    A          = 4'h3;
    B          = 4'h5;
    opcode     = 3'b000;
    capture_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("both_shift_done[%0d]", k), 32'(shift_done), 32'h0);
    end
    scan_enable = 1'b0;
    capture_en  = 1'b0;
    tick();
    check("gap_shift_done", 32'(shift_done), 32'h0);
    check("gap_pin_result", 32'(result), 32'h8);
    scan_enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("resume_scan_out[%0d]", k), 32'(scan_out), 32'h0);
      tick();
      check($sformatf("resume_shift_done[%0d]", k), 32'(shift_done), 32'(k == 15));
    end
    scan_enable = 1'b0;

    // Functional mode vectors from pins
    test_mode = 1'b0;
    foreach (vecs[i]) begin
      A      = vecs[i].a;
      B      = vecs[i].b;
      opcode = vecs[i].op;
      tick();
      check($sformatf("func_result[%0d]", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("func_zero[%0d]", i), 32'(zero_flag), 32'(vecs[i].zero));
    end

`ifdef SCAN_ALU_MISR_EN
    #3 reset = 1'b1;
    #1;
    check("misr_reset", 32'(misr_sig), 32'h0);
    tick();
    reset      = 1'b0;
    A          = 4'h3;
    B          = 4'h5;
    opcode     = 3'b000;
    capture_en = 1'b1;
    tick();
    check("misr_capture1", 32'(misr_sig), 32'b10000);
    tick();
    check("misr_capture2", 32'(misr_sig), 32'b10001);
    capture_en = 1'b0;
    tick();
    check("misr_hold", 32'(misr_sig), 32'b10001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
